// File: rtl/uart_tx_serializer.sv
// Pulls bytes from the 24-to-8 unloader over a rden/valid handshake and shifts
// each one out as an 8N1 frame (optional parity) timed by a clocks-per-bit counter.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 868,
    parameter bit PARITY_EN    = 1'b0,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       src_valid,
    output logic       src_rden,
    input  logic [7:0] src_data,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(CLKS_PER_BIT - 2);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             parity_acc;
    logic             bit_end;

    assign bit_end = (cnt == CNT_LAST);

    // Every output is set for the state being entered, so tx and the strobes
    // come straight from flops and line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            parity_acc <= 1'b0;
            tx         <= 1'b1;
            src_rden   <= 1'b0;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            src_rden <= 1'b0;
            tx_done  <= 1'b0;
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    cnt  <= '0;
                    if (enable && src_valid) begin
                        state    <= FETCH;
                        src_rden <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    shreg      <= src_data;
                    parity_acc <= 1'b0;
                    bit_idx    <= '0;
                    tx         <= 1'b0;
                    state      <= START;
                end
                START: begin
                    if (bit_end) begin
                        cnt        <= '0;
                        tx         <= shreg[0];
                        parity_acc <= parity_acc ^ shreg[0];
                        shreg      <= {1'b0, shreg[7:1]};
                        state      <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // The shifter always presents the next bit at shreg[0]; the
                // parity accumulator folds in each bit as it goes onto the line.
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            if (PARITY_EN) begin
                                tx    <= parity_acc ^ PARITY_ODD;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_idx    <= bit_idx + 1'b1;
                            tx         <= shreg[0];
                            parity_acc <= parity_acc ^ shreg[0];
                            shreg      <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        tx    <= 1'b1;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // tx_done is raised one cycle early so the registered pulse
                // lands on the final stop-bit cycle.
                STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (enable && src_valid) begin
                            state    <= FETCH;
                            src_rden <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_PENULT) begin
                            tx_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench: four serializer variants share one upstream byte model;
// a monitor decodes frames off the selected tx line and checks them against a queue.
module tb_uart_tx_serializer;

    typedef struct {
        logic [10:0] bits;
        bit          chk_gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] en_v;
    logic       src_valid;
    logic [7:0] src_data;
    logic [3:0] tx_v;
    logic [3:0] busy_v;
    logic [3:0] done_v;
    logic [3:0] rden_v;

    logic [1:0] sel;
    logic       tx_m;
    logic       busy_m;
    logic       done_m;
    int         cpb_m;
    bit         pen_m;

    exp_t       exp_q[$];
    logic [7:0] up_q[$];
    int         passed = 0;
    int         total = 0;
    int         rd_count = 0;
    time        rden_time = 0;
    time        end_time = 0;
    bit         mon_active = 1'b0;

    uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_plain (
        .clk(clk), .rst(rst), .enable(en_v[0]), .src_valid(src_valid), .src_rden(rden_v[0]),
        .src_data(src_data), .tx(tx_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]));

    uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_even (
        .clk(clk), .rst(rst), .enable(en_v[1]), .src_valid(src_valid), .src_rden(rden_v[1]),
        .src_data(src_data), .tx(tx_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]));

    uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_odd (
        .clk(clk), .rst(rst), .enable(en_v[2]), .src_valid(src_valid), .src_rden(rden_v[2]),
        .src_data(src_data), .tx(tx_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]));

    uart_tx_serializer #(.CLKS_PER_BIT(2), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_fast (
        .clk(clk), .rst(rst), .enable(en_v[3]), .src_valid(src_valid), .src_rden(rden_v[3]),
        .src_data(src_data), .tx(tx_v[3]), .busy(busy_v[3]), .tx_done(done_v[3]));

    always #5 clk = ~clk;

    always_comb begin
        tx_m   = tx_v[sel];
        busy_m = busy_v[sel];
        done_m = done_v[sel];
        cpb_m  = (sel == 2'd3) ? 2 : 4;
        pen_m  = (sel == 2'd1) || (sel == 2'd2);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic [10:0] bits, input bit chk_gap);
        exp_t e;
        e.bits    = bits;
        e.chk_gap = chk_gap;
        exp_q.push_back(e);
        up_q.push_back(b);
    endtask

    task automatic waitDone(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || mon_active) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_complete"}, 32'(n < 1000), 32'd1);
        @(negedge clk);
    endtask

    task automatic waitStart(input string name);
        int n = 0;
        while (tx_m !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_start"}, 32'(n < 200), 32'd1);
    endtask

    // Upstream unloader model: pops a byte on each read strobe, holds it through
    // LOAD, and drives junk on src_data at all other times.
    initial begin : upstream
        bit hold;
        hold      = 1'b0;
        src_valid = 1'b0;
        src_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (|rden_v) begin
                rd_count++;
                rden_time = $time;
                if (up_q.size() != 0) src_data = up_q.pop_front();
                hold = 1'b1;
            end else if (hold) begin
                hold = 1'b0;
            end else begin
                src_data = 8'($urandom);
            end
            src_valid = (up_q.size() != 0);
        end
    end

    initial begin : monitor
        exp_t        e;
        logic [10:0] obs;
        bit          aborted, width_ok, done_ok, busy_ok, have;
        int          nb, cpb;
        time         start_t;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx_m === 1'b0 && busy_m === 1'b1) begin
                mon_active = 1'b1;
                start_t    = $time;
                have       = (exp_q.size() != 0);
                if (have) e = exp_q.pop_front();
                else begin
                    e.bits    = '0;
                    e.chk_gap = 1'b0;
                end
                checkOutput("frame_expected", 32'(have), 32'd1);
                checkOutput("start_latency", 32'((start_t - rden_time) / 10), 32'd2);
                if (have && e.chk_gap)
                    checkOutput("gap_cycles", 32'((start_t - end_time) / 10 - 1), 32'd2);
                nb       = pen_m ? 11 : 10;
                cpb      = cpb_m;
                obs      = '0;
                aborted  = 1'b0;
                width_ok = 1'b1;
                done_ok  = 1'b1;
                busy_ok  = 1'b1;
                for (int k = 0; k < nb; k++) begin
                    for (int c = 0; c < cpb; c++) begin
                        if (!aborted) begin
                            if (k != 0 || c != 0) @(negedge clk);
                            if (rst !== 1'b0) aborted = 1'b1;
                            else begin
                                if (c == 0) obs[k] = tx_m;
                                else if (tx_m !== obs[k]) width_ok = 1'b0;
                                if (done_m !== 1'((k == nb - 1) && (c == cpb - 1))) done_ok = 1'b0;
                                if (busy_m !== 1'b1) busy_ok = 1'b0;
                            end
                        end
                    end
                end
                if (!aborted) begin
                    if (have) checkOutput("frame_bits", 32'(obs), 32'(e.bits));
                    checkOutput("bit_width", 32'(width_ok), 32'd1);
                    checkOutput("tx_done_timing", 32'(done_ok), 32'd1);
                    checkOutput("busy_in_frame", 32'(busy_ok), 32'd1);
                    end_time = $time;
                end
                mon_active = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        rst  = 1'b1;
        en_v = 4'b0000;
        sel  = 2'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset_tx", 32'(tx_v), 32'hF);
        checkOutput("reset_busy", 32'(busy_v), 32'h0);
        checkOutput("reset_rden", 32'(rden_v), 32'h0);
        checkOutput("reset_done", 32'(done_v), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Single byte: tx 0,1,0,1,0,0,1,0,1,1
        rd_count = 0;
        applyStimulus(8'hA5, {1'b1, 8'hA5, 1'b0}, 1'b0);
        en_v = 4'b0001;
        waitDone("single");
        checkOutput("single_reads", 32'(rd_count), 32'd1);
        checkOutput("single_idle_busy", 32'(busy_m), 32'd0);
        checkOutput("single_idle_tx", 32'(tx_m), 32'd1);

        // Unloader word 0x123456 drains low byte first, back-to-back
        en_v = 4'b0000;
        rd_count = 0;
        applyStimulus(8'h56, {1'b1, 8'h56, 1'b0}, 1'b0);
        applyStimulus(8'h34, {1'b1, 8'h34, 1'b0}, 1'b1);
        applyStimulus(8'h12, {1'b1, 8'h12, 1'b0}, 1'b1);
        en_v = 4'b0001;
        waitDone("word");
        repeat (20) @(negedge clk);
        checkOutput("word_reads", 32'(rd_count), 32'd3);
        checkOutput("word_idle_busy", 32'(busy_m), 32'd0);
        en_v = 4'b0000;

        // Even parity: 0x07 -> 1, 0x03 -> 0
        sel = 2'd1;
        applyStimulus(8'h07, {1'b1, 1'b1, 8'h07, 1'b0}, 1'b0);
        applyStimulus(8'h03, {1'b1, 1'b0, 8'h03, 1'b0}, 1'b1);
        en_v = 4'b0010;
        waitDone("even");
        en_v = 4'b0000;

        // Odd parity: 0x07 -> 0, 0x03 -> 1
        sel = 2'd2;
        applyStimulus(8'h07, {1'b1, 1'b0, 8'h07, 1'b0}, 1'b0);
        applyStimulus(8'h03, {1'b1, 1'b1, 8'h03, 1'b0}, 1'b1);
        en_v = 4'b0100;
        waitDone("odd");
        en_v = 4'b0000;

        // Reset during data bit 3 (cycle 18 of the frame)
        sel = 2'd0;
        applyStimulus(8'hA5, {1'b1, 8'hA5, 1'b0}, 1'b0);
        en_v = 4'b0001;
        waitStart("abort");
        repeat (17) @(negedge clk);
        checkOutput("abort_pre_bit3", 32'(tx_m), 32'd0);
        checkOutput("abort_pre_busy", 32'(busy_m), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_tx", 32'(tx_m), 32'd1);
        checkOutput("abort_busy", 32'(busy_m), 32'd0);
        checkOutput("abort_done", 32'(done_m), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'hC6, {1'b1, 8'hC6, 1'b0}, 1'b0);
        waitDone("restart");
        en_v = 4'b0000;

        // enable low blocks fetches; dropping it mid-frame lets the frame finish
        rd_count = 0;
        up_q.push_back(8'h3C);
        repeat (30) @(negedge clk);
        checkOutput("disabled_reads", 32'(rd_count), 32'd0);
        checkOutput("disabled_tx", 32'(tx_m), 32'd1);
        checkOutput("disabled_busy", 32'(busy_m), 32'd0);
        begin
            exp_t e;
            e.bits    = {1'b0, 1'b1, 8'h3C, 1'b0};
            e.chk_gap = 1'b0;
            exp_q.push_back(e);
        end
        up_q.push_back(8'hC3);
        en_v = 4'b0001;
        waitStart("midfrm");
        en_v = 4'b0000;
        waitDone("midfrm");
        repeat (20) @(negedge clk);
        checkOutput("midfrm_reads", 32'(rd_count), 32'd1);
        checkOutput("midfrm_left", 32'(up_q.size()), 32'd1);
        checkOutput("midfrm_busy", 32'(busy_m), 32'd0);
        checkOutput("midfrm_tx", 32'(tx_m), 32'd1);
        up_q.delete();
        repeat (2) @(negedge clk);

        // Minimum bit time, back-to-back 0xFF then 0x00
        sel = 2'd3;
        rd_count = 0;
        applyStimulus(8'hFF, {1'b1, 8'hFF, 1'b0}, 1'b0);
        applyStimulus(8'h00, {1'b1, 8'h00, 1'b0}, 1'b1);
        en_v = 4'b1000;
        waitDone("fast");
        en_v = 4'b0000;
        checkOutput("fast_reads", 32'(rd_count), 32'd2);
        checkOutput("fast_idle_busy", 32'(busy_m), 32'd0);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
